decode_queue: RTL and testbench

- Parametrised instruction decode buffer between fetch and the existing combinational decode/issue logic.
- Accepts fetched words over a valid/ready handshake and stores them in a DEPTH-entry circular queue.
- Each entry is pre-classified and tagged with its reserved-instruction flag, branch-delay-slot flag and fetch-address-error flag.
- Presents the oldest entry to the decode stage with its own valid/ready handshake, and supports a single-cycle flush on exception or eret.

---
 rtl/decode_queue_pkg.sv | 52 +++++
 rtl/decode_queue_inst_classifier.sv | 65 ++++++
 rtl/decode_queue.sv | 93 +++++++++
 tb/tb_decode_queue.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_queue_pkg.sv
// Shared constants for the decode queue: class codes, MIPS opcode/func/rt/rs
// encodings recognised by the classifier, and the stored entry layout.
package decode_queue_pkg;

    localparam int unsigned INST_W  = 32;
    localparam int unsigned CLASS_W = 4;

    localparam logic [CLASS_W-1:0] CLASS_ALU    = 4'd0;
    localparam logic [CLASS_W-1:0] CLASS_LOAD   = 4'd1;
    localparam logic [CLASS_W-1:0] CLASS_STORE  = 4'd2;
    localparam logic [CLASS_W-1:0] CLASS_BRANCH = 4'd3;
    localparam logic [CLASS_W-1:0] CLASS_JUMP   = 4'd4;
    localparam logic [CLASS_W-1:0] CLASS_MULDIV = 4'd5;
    localparam logic [CLASS_W-1:0] CLASS_HILO   = 4'd6;
    localparam logic [CLASS_W-1:0] CLASS_CP0    = 4'd7;
    localparam logic [CLASS_W-1:0] CLASS_TRAP   = 4'd8;

    localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J    = 6'h02, OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04, OP_BNE   = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ = 6'h07;
    localparam logic [5:0] OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI = 6'h0C, OP_ORI   = 6'h0D, OP_XORI = 6'h0E, OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_COP0 = 6'h10;
    localparam logic [5:0] OP_LB   = 6'h20, OP_LH    = 6'h21, OP_LWL  = 6'h22, OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU  = 6'h24, OP_LHU   = 6'h25, OP_LWR  = 6'h26;
    localparam logic [5:0] OP_SB   = 6'h28, OP_SH    = 6'h29, OP_SWL  = 6'h2A, OP_SW    = 6'h2B;
    localparam logic [5:0] OP_SWR  = 6'h2E;

    localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04, FN_SRLV = 6'h06, FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08, FN_JALR = 6'h09;
    localparam logic [5:0] FN_SYSCALL = 6'h0C, FN_BREAK = 6'h0D;
    localparam logic [5:0] FN_MFHI = 6'h10, FN_MTHI  = 6'h11, FN_MFLO = 6'h12, FN_MTLO = 6'h13;
    localparam logic [5:0] FN_MULT = 6'h18, FN_MULTU = 6'h19, FN_DIV  = 6'h1A, FN_DIVU = 6'h1B;
    localparam logic [5:0] FN_ADD  = 6'h20, FN_ADDU  = 6'h21, FN_SUB  = 6'h22, FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24, FN_OR    = 6'h25, FN_XOR  = 6'h26, FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A, FN_SLTU  = 6'h2B;
    localparam logic [5:0] FN_ERET = 6'h18;

    localparam logic [4:0] RT_BLTZ   = 5'h00, RT_BGEZ   = 5'h01;
    localparam logic [4:0] RT_BLTZAL = 5'h10, RT_BGEZAL = 5'h11;
    localparam logic [4:0] RS_MF     = 5'h00, RS_MT     = 5'h04;

    typedef struct packed {
        logic [INST_W-1:0]  inst;
        logic [CLASS_W-1:0] cls;
        logic               ri;
        logic               bd;
        logic               adel;
    } entry_t;

endpackage

// File: rtl/decode_queue_inst_classifier.sv
// Combinational instruction classifier used on the queue push path.
// Unrecognised encodings are reported as ALU with the reserved flag set.
module inst_classifier
    import decode_queue_pkg::*;
(
    input  logic [INST_W-1:0]  inst,
    output logic [CLASS_W-1:0] inst_class,
    output logic               ri,
    output logic               is_ctrl_xfer
);

    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       unused_bits;

    assign op = inst[31:26];
    assign rs = inst[25:21];
    assign rt = inst[20:16];
    assign fn = inst[5:0];
    assign unused_bits = ^inst[15:6];

    always_comb begin
        inst_class = CLASS_ALU;
        ri         = 1'b0;
        case (op)
            OP_SPECIAL: begin
                case (fn)
                    FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
                    FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
                    FN_XOR, FN_NOR, FN_SLT, FN_SLTU:            inst_class = CLASS_ALU;
                    FN_JR, FN_JALR:                             inst_class = CLASS_JUMP;
                    FN_SYSCALL, FN_BREAK:                       inst_class = CLASS_TRAP;
                    FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO:         inst_class = CLASS_HILO;
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU:         inst_class = CLASS_MULDIV;
                    default:                                    ri = 1'b1;
                endcase
            end
            OP_REGIMM: begin
                case (rt)
                    RT_BLTZ, RT_BGEZ, RT_BLTZAL, RT_BGEZAL:     inst_class = CLASS_BRANCH;
                    default:                                    ri = 1'b1;
                endcase
            end
            OP_J, OP_JAL:                                       inst_class = CLASS_JUMP;
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:                   inst_class = CLASS_BRANCH;
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI:                   inst_class = CLASS_ALU;
            OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR: inst_class = CLASS_LOAD;
            OP_SB, OP_SH, OP_SWL, OP_SW, OP_SWR:                inst_class = CLASS_STORE;
            OP_COP0: begin
                // eret is the CO-format op (rs[4] set) with func 0x18
                if (rs == RS_MF || rs == RS_MT || (rs[4] && fn == FN_ERET))
                    inst_class = CLASS_CP0;
                else
                    ri = 1'b1;
            end
            default:                                            ri = 1'b1;
        endcase
    end

    assign is_ctrl_xfer = (inst_class == CLASS_BRANCH) || (inst_class == CLASS_JUMP);

endmodule

// File: rtl/decode_queue.sv
// Circular decode buffer between fetch and decode; entries are classified and
// tagged (reserved, delay slot, address error) as they are pushed.
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PC_W  = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_inst,
    input  logic [PC_W-1:0]          in_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_inst,
    output logic [PC_W-1:0]          out_pc,
    output logic [3:0]               out_class,
    output logic                     out_ri,
    output logic                     out_bd,
    output logic                     out_adel,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    entry_t               mem    [DEPTH];
    logic [PC_W-1:0]      pc_mem [DEPTH];
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     wr_ptr;
    logic                 bd_pending;
    logic [CLASS_W-1:0]   in_class;
    logic                 in_ri;
    logic                 in_ctrl;
    logic                 push;
    logic                 pop;

    inst_classifier u_classifier (
        .inst         (in_inst),
        .inst_class   (in_class),
        .ri           (in_ri),
        .is_ctrl_xfer (in_ctrl)
    );

    assign in_ready  = (count != FULL_CNT);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    assign out_inst  = mem[rd_ptr].inst;
    assign out_pc    = pc_mem[rd_ptr];
    assign out_class = mem[rd_ptr].cls;
    assign out_ri    = mem[rd_ptr].ri;
    assign out_bd    = mem[rd_ptr].bd;
    assign out_adel  = mem[rd_ptr].adel;

    always_ff @(posedge clk) begin
        if (reset) begin
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            bd_pending <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[PTR_W'(i)]    <= '0;
                pc_mem[PTR_W'(i)] <= '0;
            end
        end else if (flush) begin
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            bd_pending <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr]    <= '{inst: in_inst, cls: in_class, ri: in_ri,
                                    bd: bd_pending, adel: (in_pc[1:0] != 2'b00)};
                pc_mem[wr_ptr] <= in_pc;
                wr_ptr         <= wr_ptr + PTR_W'(1);
                bd_pending     <= in_ctrl;
            end
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)
                count <= count + CNT_W'(1);
            else if (pop && !push)
                count <= count - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: directed scenarios plus a randomized
// run against a queue-based reference model with a table-driven classifier.
module tb_decode_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned PC_W  = 32;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            reset, flush, in_valid, out_ready;
    logic [31:0]     in_inst;
    logic [PC_W-1:0] in_pc;
    logic            in_ready, out_valid, out_ri, out_bd, out_adel;
    logic [31:0]     out_inst;
    logic [PC_W-1:0] out_pc;
    logic [3:0]      out_class;
    logic [CW-1:0]   count;

    always #5 clk = ~clk;

    decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
        .out_class(out_class), .out_ri(out_ri), .out_bd(out_bd), .out_adel(out_adel),
        .count(count)
    );

    typedef struct {
        logic [31:0]     inst;
        logic [PC_W-1:0] pc;
        logic [3:0]      cls;
        logic            ri, bd, adel;
    } ent_t;

    typedef struct {
        logic [31:0] val;
        logic [31:0] mask;
        logic [3:0]  cls;
    } rule_t;

    ent_t  mq[$];
    rule_t rules[$];
    logic  m_bd;
    int    n_checks = 0;
    int    n_errors = 0;

    task automatic add(input logic [31:0] val, input logic [31:0] mask, input logic [3:0] cls);
        rule_t r;
        r.val = val; r.mask = mask; r.cls = cls;
        rules.push_back(r);
    endtask

    task automatic init_rules();
        logic [31:0] opm, fnm, rtm;
        opm = 32'hFC000000; fnm = 32'hFC00003F; rtm = 32'hFC1F0000;
        // opcode-only encodings
        add(32'h08000000, opm, 4); add(32'h0C000000, opm, 4);
        add(32'h10000000, opm, 3); add(32'h14000000, opm, 3); add(32'h18000000, opm, 3); add(32'h1C000000, opm, 3);
        add(32'h20000000, opm, 0); add(32'h24000000, opm, 0); add(32'h28000000, opm, 0); add(32'h2C000000, opm, 0);
        add(32'h30000000, opm, 0); add(32'h34000000, opm, 0); add(32'h38000000, opm, 0); add(32'h3C000000, opm, 0);
        add(32'h80000000, opm, 1); add(32'h84000000, opm, 1); add(32'h88000000, opm, 1); add(32'h8C000000, opm, 1);
        add(32'h90000000, opm, 1); add(32'h94000000, opm, 1); add(32'h98000000, opm, 1);
        add(32'hA0000000, opm, 2); add(32'hA4000000, opm, 2); add(32'hA8000000, opm, 2); add(32'hAC000000, opm, 2);
        add(32'hB8000000, opm, 2);
        // SPECIAL func encodings
        add(32'h00, fnm, 0); add(32'h02, fnm, 0); add(32'h03, fnm, 0); add(32'h04, fnm, 0); add(32'h06, fnm, 0);
        add(32'h07, fnm, 0); add(32'h08, fnm, 4); add(32'h09, fnm, 4); add(32'h0C, fnm, 8); add(32'h0D, fnm, 8);
        add(32'h10, fnm, 6); add(32'h11, fnm, 6); add(32'h12, fnm, 6); add(32'h13, fnm, 6);
        add(32'h18, fnm, 5); add(32'h19, fnm, 5); add(32'h1A, fnm, 5); add(32'h1B, fnm, 5);
        add(32'h20, fnm, 0); add(32'h21, fnm, 0); add(32'h22, fnm, 0); add(32'h23, fnm, 0); add(32'h24, fnm, 0);
        add(32'h25, fnm, 0); add(32'h26, fnm, 0); add(32'h27, fnm, 0); add(32'h2A, fnm, 0); add(32'h2B, fnm, 0);
        // REGIMM branches and CP0
        add(32'h04000000, rtm, 3); add(32'h04010000, rtm, 3); add(32'h04100000, rtm, 3); add(32'h04110000, rtm, 3);
        add(32'h40000000, 32'hFFE00000, 7); add(32'h40800000, 32'hFFE00000, 7); add(32'h42000018, 32'hFE00003F, 7);
    endtask

    function automatic void classify(input logic [31:0] w, output logic [3:0] c, output logic r);
        c = 4'd0;
        r = 1'b1;
        foreach (rules[i])
            if ((w & rules[i].mask) == rules[i].val) begin
                c = rules[i].cls;
                r = 1'b0;
            end
    endfunction

    function automatic logic [31:0] rand_inst();
        int unsigned k;
        logic [31:0] fill;
        if ($urandom_range(0, 9) < 8) begin
            k    = $urandom_range(0, rules.size() - 1);
            fill = $urandom;
            return (rules[k].val & rules[k].mask) | (fill & ~rules[k].mask);
        end
        return $urandom;
    endfunction

    // Advance the model using the inputs now on the pins, then clock the DUT.
    task automatic tick();
        ent_t e;
        int unsigned sz;
        bit push, pop;
        sz = mq.size();
        if (reset || flush) begin
            mq.delete();
            m_bd = 1'b0;
        end else begin
            push = in_valid && (sz != DEPTH);
            pop  = out_ready && (sz != 0);
            if (pop) void'(mq.pop_front());
            if (push) begin
                e.inst = in_inst;
                e.pc   = in_pc;
                classify(in_inst, e.cls, e.ri);
                e.bd   = m_bd;
                e.adel = (in_pc[1:0] != 2'b00);
                mq.push_back(e);
                m_bd = (e.cls == 4'd3) || (e.cls == 4'd4);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_one(input logic [31:0] inst, input logic [PC_W-1:0] pc);
        in_valid = 1'b1; in_inst = inst; in_pc = pc;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
        n_checks++; if (count !== '0) begin n_errors++; $display("FAIL reset_count got %0d exp 0", count); end
        n_checks++;
        if ({out_inst, out_pc, out_class, out_ri, out_bd, out_adel} !== '0) begin
            n_errors++;
            $display("FAIL reset_data got inst=%h pc=%h cls=%0d ri=%0b bd=%0b adel=%0b exp all 0",
                     out_inst, out_pc, out_class, out_ri, out_bd, out_adel);
        end
    endtask

    task automatic test_single_push();
        push_one(32'h24020005, 32'hBFC00000);
        n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL single_valid got %0b exp 1", out_valid); end
        n_checks++; if (count !== CW'(1)) begin n_errors++; $display("FAIL single_count got %0d exp 1", count); end
        n_checks++; if (out_inst !== 32'h24020005) begin n_errors++; $display("FAIL single_inst got %h exp 24020005", out_inst); end
        n_checks++; if (out_pc !== 32'hBFC00000) begin n_errors++; $display("FAIL single_pc got %h exp bfc00000", out_pc); end
        n_checks++;
        if ({out_class, out_ri, out_bd, out_adel} !== 7'b0) begin
            n_errors++;
            $display("FAIL single_tags got cls=%0d ri=%0b bd=%0b adel=%0b exp 0 0 0 0", out_class, out_ri, out_bd, out_adel);
        end
        pop_one();
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL single_drain got valid %0b exp 0", out_valid); end
    endtask

    task automatic test_delay_slot();
        push_one(32'h10000003, 32'h100);
        push_one(32'h00000000, 32'h104);
        push_one(32'h24020005, 32'h108);
        n_checks++; if (count !== CW'(3)) begin n_errors++; $display("FAIL ds_count got %0d exp 3", count); end
        n_checks++; if ({out_class, out_bd} !== {4'd3, 1'b0}) begin n_errors++; $display("FAIL ds_branch got cls=%0d bd=%0b exp 3 0", out_class, out_bd); end
        pop_one();
        n_checks++; if ({out_class, out_bd} !== {4'd0, 1'b1}) begin n_errors++; $display("FAIL ds_slot got cls=%0d bd=%0b exp 0 1", out_class, out_bd); end
        pop_one();
        n_checks++; if ({out_pc, out_bd} !== {32'h108, 1'b0}) begin n_errors++; $display("FAIL ds_after got pc=%h bd=%0b exp 108 0", out_pc, out_bd); end
        pop_one();
    endtask

    task automatic test_ri_adel();
        push_one(32'hFC000000, 32'h200);
        push_one(32'h24020005, 32'hBFC00002);
        n_checks++;
        if ({out_ri, out_class, out_adel} !== {1'b1, 4'd0, 1'b0}) begin
            n_errors++; $display("FAIL ri_flag got ri=%0b cls=%0d adel=%0b exp 1 0 0", out_ri, out_class, out_adel);
        end
        pop_one();
        n_checks++;
        if ({out_ri, out_class, out_adel} !== {1'b0, 4'd0, 1'b1}) begin
            n_errors++; $display("FAIL adel_flag got ri=%0b cls=%0d adel=%0b exp 0 0 1", out_ri, out_class, out_adel);
        end
        pop_one();
    endtask

    task automatic test_full();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_inst = 32'h24000000 | 32'(i);
            in_pc   = 32'h300 + 32'(4 * i);
            tick();
        end
        n_checks++; if ({in_ready, count} !== {1'b0, CW'(4)}) begin n_errors++; $display("FAIL full_reach got ready=%0b count=%0d exp 0 4", in_ready, count); end
        in_inst = 32'h24000004;
        in_pc   = 32'h310;
        tick();
        n_checks++; if ({in_ready, count} !== {1'b0, CW'(4)}) begin n_errors++; $display("FAIL full_hold got ready=%0b count=%0d exp 0 4", in_ready, count); end
        out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL full_no_bypass got ready=%0b exp 0", in_ready); end
        tick();
        out_ready = 1'b0;
        n_checks++;
        if ({in_ready, count, out_pc} !== {1'b1, CW'(3), 32'h304}) begin
            n_errors++; $display("FAIL full_pop got ready=%0b count=%0d pc=%h exp 1 3 304", in_ready, count, out_pc);
        end
        tick();
        in_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            n_checks++;
            if (out_pc !== 32'h300 + 32'(4 * k)) begin n_errors++; $display("FAIL full_order got pc=%h exp %h", out_pc, 32'h300 + 32'(4 * k)); end
            pop_one();
        end
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL full_drain got valid=%0b exp 0", out_valid); end
    endtask

    task automatic test_flush();
        push_one(32'h00000000, 32'h400);
        push_one(32'h00000000, 32'h404);
        push_one(32'h10000003, 32'h408);
        flush = 1'b1; in_valid = 1'b1; in_inst = 32'h24420001; in_pc = 32'h40C;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL flush_ready got %0b exp 1", in_ready); end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        n_checks++;
        if ({count, out_valid, in_ready} !== {CW'(0), 1'b0, 1'b1}) begin
            n_errors++; $display("FAIL flush_empty got count=%0d valid=%0b ready=%0b exp 0 0 1", count, out_valid, in_ready);
        end
        push_one(32'h00000000, 32'h500);
        n_checks++;
        if ({count, out_pc, out_bd} !== {CW'(1), 32'h500, 1'b0}) begin
            n_errors++; $display("FAIL flush_next got count=%0d pc=%h bd=%0b exp 1 500 0", count, out_pc, out_bd);
        end
        pop_one();
    endtask

    task automatic test_streaming();
        logic [31:0] w;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            w = rand_inst();
            in_inst = w;
            in_pc   = 32'(4 * i);
            tick();
            n_checks++;
            if ({count, out_pc, out_inst} !== {CW'(1), 32'(4 * i), w}) begin
                n_errors++; $display("FAIL stream_%0d got count=%0d pc=%h inst=%h exp 1 %h %h", i, count, out_pc, out_inst, 32'(4 * i), w);
            end
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        n_checks++; if (count !== CW'(0)) begin n_errors++; $display("FAIL stream_drain got count=%0d exp 0", count); end
    endtask

    task automatic test_random();
        ent_t h;
        for (int c = 0; c < 600; c++) begin
            reset     = ($urandom_range(0, 149) == 0);
            flush     = ($urandom_range(0, 29) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_inst   = rand_inst();
            in_pc     = $urandom;
            tick();
            n_checks++;
            if ({count, out_valid, in_ready} !== {CW'(mq.size()), mq.size() != 0, mq.size() != DEPTH}) begin
                n_errors++;
                $display("FAIL rand_ctl cycle %0d got count=%0d valid=%0b ready=%0b exp count=%0d", c, count, out_valid, in_ready, mq.size());
            end
            if (mq.size() != 0) begin
                h = mq[0];
                n_checks++;
                if ({out_inst, out_pc, out_class, out_ri, out_bd, out_adel} !== {h.inst, h.pc, h.cls, h.ri, h.bd, h.adel}) begin
                    n_errors++;
                    $display("FAIL rand_head cycle %0d got %h/%h/%0d/%0b%0b%0b exp %h/%h/%0d/%0b%0b%0b", c,
                             out_inst, out_pc, out_class, out_ri, out_bd, out_adel, h.inst, h.pc, h.cls, h.ri, h.bd, h.adel);
                end
            end
        end
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = '0; in_pc = '0; m_bd = 1'b0;
        init_rules();
        @(negedge clk);
        test_reset();
        test_single_push();
        test_delay_slot();
        test_ri_adel();
        test_full();
        test_flush();
        test_streaming();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
